down_timer: RTL and testbench

Synchronous, loadable 4-bit (parameterizable) down counter with terminal-count pulse and optional auto-reload. It is the down-counting, fully synchronous counterpart to the team's ripple up-counter. It serves as a programmable interval timer or divider. All state changes happen on the rising edge of `clk`; there are no derived or rippled clocks.

---
 rtl/down_timer.sv | 79 +++++++
 tb/tb_down_timer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down counter with one-cycle terminal-count pulse and optional auto-reload.
// Latency: q/tc/busy update one cycle after inputs are sampled; no backpressure, en simply stalls the count.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tc;
  logic             w_tc_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (i_clear) begin
      w_q_nxt     = '0;
      w_state_nxt = S_IDLE;
    end else if (i_load) begin
      // A zero load value parks the timer instead of starting it.
      w_q_nxt      = i_load_val;
      w_reload_nxt = i_load_val;
      w_state_nxt  = (i_load_val != '0) ? S_RUN : S_IDLE;
    end else if (r_state == S_RUN && i_en) begin
      if (r_q == WIDTH'(1)) begin
        w_tc_nxt = 1'b1;
        if (i_auto_reload) begin
          w_q_nxt = r_reload;
        end else begin
          w_q_nxt     = '0;
          w_state_nxt = S_IDLE;
        end
      end else begin
        w_q_nxt = r_q - WIDTH'(1);
      end
    end
  end

  assign o_q    = r_q;
  assign o_tc   = r_tc;
  assign o_busy = (r_state == S_RUN);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: hand-computed q/tc/busy sequences, checked 1 ns after each rising edge.
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] q;
  logic       tc;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  down_timer #(.WIDTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (clear),
    .i_load       (load),
    .i_load_val   (load_val),
    .i_en         (en),
    .i_auto_reload(auto_reload),
    .o_q          (q),
    .o_tc         (tc),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eq, input logic etc, input logic ebusy);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".tc"}, 32'(tc), 32'(etc));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  // Hand-computed q after each en value in periodic mode starting from 4.
  logic [3:0] gap_en   [6] = '{1, 0, 1, 1, 0, 1};
  logic [3:0] gap_q    [6] = '{3, 3, 2, 1, 1, 4};
  logic       gap_tc   [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b0; clear = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b0; auto_reload = 1'b0;

    // Reset beats a simultaneous load.
    tick(); tick();
    chk_out("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("post_reset_load", 4'd5, 1'b0, 1'b1);

    // One-shot of 3.
    load_val = 4'd3; en = 1'b1;
    tick();
    chk_out("os_load", 4'd3, 1'b0, 1'b1);
    load = 1'b0;
    tick(); chk_out("os_2", 4'd2, 1'b0, 1'b1);
    tick(); chk_out("os_1", 4'd1, 1'b0, 1'b1);
    tick(); chk_out("os_tc", 4'd0, 1'b1, 1'b0);
    tick(); chk_out("os_after", 4'd0, 1'b0, 1'b0);

    // Periodic with enable gaps.
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b1; en = 1'b0;
    tick(); chk_out("per_load", 4'd4, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = gap_en[i][0];
      tick();
      chk_out($sformatf("per_gap%0d", i), gap_q[i], gap_tc[i], 1'b1);
    end

    // Maximum period: tc every 15 enabled cycles, no dead cycle.
    load = 1'b1; load_val = 4'd15; en = 1'b1;
    tick(); chk_out("max_load", 4'd15, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i % 15 == 14) chk_out($sformatf("max%0d", i), 4'd15, 1'b1, 1'b1);
      else              chk_out($sformatf("max%0d", i), 4'(14 - (i % 15)), 1'b0, 1'b1);
    end

    // Minimum period: tc every cycle with q pinned at 1.
    load = 1'b1; load_val = 4'd1;
    tick(); chk_out("min_load", 4'd1, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("min%0d", i), 4'd1, 1'b1, 1'b1);
    end

    // Load on the terminal step wins and suppresses tc.
    load = 1'b1; load_val = 4'd6;
    tick(); chk_out("load_vs_tc", 4'd6, 1'b0, 1'b1);

    // Clear beats load.
    clear = 1'b1; load_val = 4'd7;
    tick(); chk_out("clear_vs_load", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; load = 1'b0;
    tick(); chk_out("idle_ignores_en", 4'd0, 1'b0, 1'b0);

    // Load of zero parks the timer.
    load = 1'b1; load_val = 4'd5;
    tick(); chk_out("pre_zero_load", 4'd5, 1'b0, 1'b1);
    load_val = 4'd0;
    tick(); chk_out("zero_load", 4'd0, 1'b0, 1'b0);
    load = 1'b0;
    tick(); chk_out("zero_load_hold", 4'd0, 1'b0, 1'b0);

    // Reset mid-run, then en alone cannot restart.
    load = 1'b1; load_val = 4'd9; auto_reload = 1'b0;
    tick(); chk_out("rr_load", 4'd9, 1'b0, 1'b1);
    load = 1'b0;
    tick(); tick(); tick(); tick();
    chk_out("rr_5", 4'd5, 1'b0, 1'b1);
    rst = 1'b0;
    tick(); chk_out("rr_reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("rr_idle%0d", i), 4'd0, 1'b0, 1'b0);
    end

    // A reset glitch between edges is not seen.
    load = 1'b1; load_val = 4'd2;
    tick(); chk_out("gl_load", 4'd2, 1'b0, 1'b1);
    load = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick(); chk_out("gl_1", 4'd1, 1'b0, 1'b1);
    tick(); chk_out("gl_tc", 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
